seg_bus_decoder: RTL
====================

SEG_BUS_DECODER -- requirements
Module: seg_bus_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: the number of consecutive identical bus samples needed to accept a bus value (legal range 2..15).
REQ-002 SHALL have parameter TIMEOUT, default 255: the maximum number of cycles between accepts inside a frame (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port seg_in, input, 16 bits: the multiplexed display bus. Bits 7:1 carry segments; bits 14:10 carry digit select; bits 0, 8, 9 and 15 are reserved and must be 0.
REQ-006 SHALL have ports dig_one, dig_two, dig_three and dig_four, output, 4 bits each: the recovered hex digits.
REQ-007 SHALL have port dig_valid, output, 4 bits: bit 3 corresponds to dig_one and bit 0 to dig_four; a set bit means that digit was captured in the current or last frame.
REQ-008 SHALL have ports frame_done, seg_err, sel_err and timeout, output, 1 bit each: single-cycle pulses.

Function
REQ-009 SHALL register seg_in once, and SHALL compare each registered sample with the previous one. The run counter increments on a match (saturating at 15) and loads 1 on a mismatch.
REQ-010 SHALL raise an internal accept on the cycle the run counter first equals STABLE_CYCLES. A held value SHALL produce exactly one accept, however long it is held.
REQ-011 SHALL apply outputs for an accept on the clock edge after the STABLE_CYCLES-th identical sample. With the default parameter, a value sampled at edges 0..3 updates outputs at edge 4.
REQ-012 SHALL map the select field as follows: 10000 to dig_one, 01000 to dig_two, 00010 to dig_three, 00001 to dig_four.
REQ-013 SHALL treat select 00000 with all reserved bits 0 as idle: the accept is ignored, with no pulse and no state change.
REQ-014 SHALL pulse sel_err, and make no digit write, on an accept whose select field is any other code or whose reserved bits are nonzero.
REQ-015 SHALL decode segments 6..0 as follows: 0=1110111, 1=0100100, 2=0011111, 3=0111110, 4=1101100, 5=1111010, 6=1111011, 7=0110100, 8=1111111, 9=1111110, A=1111101, B=1101011, C=1010011, D=0101111, E=1011011, F=1011001.
REQ-016 SHALL pulse seg_err, and make no digit write, on a valid select carrying an unlisted segment pattern; sel_err SHALL take precedence over seg_err.
REQ-017 SHALL, on a valid accept, write the decoded value to the selected digit, set its dig_valid bit, and set its bit in the internal frame mask.
REQ-018 SHALL implement an FSM with states IDLE and COLLECT. IDLE moves to COLLECT on the first valid accept.
REQ-019 SHALL, in COLLECT, pulse frame_done when the frame mask reaches 1111, then clear the mask and return to IDLE.
REQ-020 SHALL let a repeated digit within a frame overwrite the earlier value without affecting completion.
REQ-021 SHALL run a timeout counter only in COLLECT: it clears on every valid accept, and when it reaches TIMEOUT it pulses timeout, clears the mask and dig_valid, and returns to IDLE; digit values are retained.
REQ-022 SHALL give a valid accept priority over timeout expiry in the same cycle.
REQ-023 SHALL let an error accept in COLLECT neither clear the timeout counter nor alter the frame mask.

Reset
REQ-024 SHALL, while rst_n is 0, set to 0 all digits, dig_valid, all pulse outputs, the run counter, the timeout counter, the mask and the input register, and SHALL hold the FSM in IDLE.
REQ-025 SHALL make reset asserted mid-frame discard the partial frame immediately; the first accept after release needs a fresh STABLE_CYCLES run.

Verification
REQ-026 SHALL cover reset: assert rst_n=0 mid-operation -> all outputs read 0 asynchronously, before the next clock edge.
REQ-027 SHALL cover a full frame: hold 0x4048, 0x203E, 0x087C and 0x04D8 for 16 cycles each -> dig_one..dig_four = 1, 2, 3, 4; dig_valid = 1111; exactly one frame_done pulse.
REQ-028 SHALL cover glitch rejection: hold 0x4048 for 4 cycles, then 0x40FC for 3 cycles, then 0x0000 -> dig_one = 1 and no pulse for 0x40FC.
REQ-029 SHALL cover errors: 0x4002 held for 4 cycles -> one seg_err pulse and dig_one unchanged; 0x1048 and 0xC048 -> one sel_err pulse each.
REQ-030 SHALL cover timeout: 0x4048, then 0x0000 held for 260 cycles -> one timeout pulse 255 cycles after the accept, dig_valid = 0000, dig_one still 1.
REQ-031 SHALL cover the same-cycle corner: the fourth digit accepted in the same cycle the timeout expires -> frame_done pulses and timeout does not.

Source files
------------

// File: rtl/seg_bus_decoder.sv
// seg_bus_decoder: recovers four hex digits from a multiplexed 7-segment display bus
// Ports: clk, rst_n (async, active-low); seg_in = {rsv, sel[4:0], rsv, rsv, seg[6:0], rsv};
//        dig_one..dig_four recovered digits; dig_valid per-digit flags (bit 3 = dig_one);
//        frame_done, seg_err, sel_err, timeout are single-cycle pulses
module seg_bus_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seg_in,
    output logic [3:0]  dig_one,
    output logic [3:0]  dig_two,
    output logic [3:0]  dig_three,
    output logic [3:0]  dig_four,
    output logic [3:0]  dig_valid,
    output logic        frame_done,
    output logic        seg_err,
    output logic        sel_err,
    output logic        timeout
);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t      state, state_n;
    logic [15:0] smp;
    logic [3:0]  run;
    logic        acc;
    logic [3:0]  mask, mask_n, valid_n, d1_n, d2_n, d3_n, d4_n, hit;
    logic [7:0]  tcnt, tcnt_n;
    logic        fd_n, se_n, sl_n, to_n;
    logic [4:0]  sel, dec;
    logic        rsv, idle, good_sel, wr;

    // {pattern known, hex value}
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        case (s)
            7'b1110111: return 5'h10;
            7'b0100100: return 5'h11;
            7'b0011111: return 5'h12;
            7'b0111110: return 5'h13;
            7'b1101100: return 5'h14;
            7'b1111010: return 5'h15;
            7'b1111011: return 5'h16;
            7'b0110100: return 5'h17;
            7'b1111111: return 5'h18;
            7'b1111110: return 5'h19;
            7'b1111101: return 5'h1a;
            7'b1101011: return 5'h1b;
            7'b1010011: return 5'h1c;
            7'b0101111: return 5'h1d;
            7'b1011011: return 5'h1e;
            7'b1011001: return 5'h1f;
            default:    return 5'h00;
        endcase
    endfunction

    // acc is high for the single cycle in which run first equals STABLE_CYCLES,
    // so smp still holds the accepted value while acc is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp <= '0;
            run <= '0;
            acc <= 1'b0;
        end else begin
            smp <= seg_in;
            run <= (seg_in != smp) ? 4'd1 : (run == 4'd15) ? run : run + 4'd1;
            acc <= (seg_in == smp) && (run == 4'(STABLE_CYCLES - 1));
        end
    end

    assign sel = smp[14:10];
    assign rsv = smp[15] | smp[9] | smp[8] | smp[0];
    assign hit = (sel == 5'b10000) ? 4'b1000 :
                 (sel == 5'b01000) ? 4'b0100 :
                 (sel == 5'b00010) ? 4'b0010 :
                 (sel == 5'b00001) ? 4'b0001 : 4'b0000;
    assign idle = (sel == 5'd0) && !rsv;
    assign good_sel = !rsv && |hit;
    assign dec = seg_decode(smp[7:1]);
    assign wr = acc && good_sel && dec[4];

    always_comb begin
        state_n = state;
        mask_n  = mask;
        tcnt_n  = tcnt;
        valid_n = dig_valid;
        fd_n    = 1'b0;
        to_n    = 1'b0;
        sl_n    = acc && !idle && !good_sel;
        se_n    = acc && good_sel && !dec[4];
        d1_n    = (wr && hit[3]) ? dec[3:0] : dig_one;
        d2_n    = (wr && hit[2]) ? dec[3:0] : dig_two;
        d3_n    = (wr && hit[1]) ? dec[3:0] : dig_three;
        d4_n    = (wr && hit[0]) ? dec[3:0] : dig_four;
        if (wr) begin
            valid_n = dig_valid | hit;
            tcnt_n  = '0;
            if ((mask | hit) == 4'hf) begin
                fd_n    = 1'b1;
                mask_n  = '0;
                state_n = IDLE;
            end else begin
                mask_n  = mask | hit;
                state_n = COLLECT;
            end
        end else if (state == COLLECT) begin
            if (tcnt == 8'(TIMEOUT - 1)) begin
                to_n    = 1'b1;
                mask_n  = '0;
                valid_n = '0;
                tcnt_n  = '0;
                state_n = IDLE;
            end else begin
                tcnt_n = tcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask       <= '0;
            tcnt       <= '0;
            dig_valid  <= '0;
            dig_one    <= '0;
            dig_two    <= '0;
            dig_three  <= '0;
            dig_four   <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            sel_err    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            mask       <= mask_n;
            tcnt       <= tcnt_n;
            dig_valid  <= valid_n;
            dig_one    <= d1_n;
            dig_two    <= d2_n;
            dig_three  <= d3_n;
            dig_four   <= d4_n;
            frame_done <= fd_n;
            seg_err    <= se_n;
            sel_err    <= sl_n;
            timeout    <= to_n;
        end
    end
endmodule
